// File: rtl/spi_axi_pkg.sv
// Shared types and constants for the QSPI flash AXI controllers.
// Holds AXI response/burst codes, the write FSM states and a beat-size helper.
package spi_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT,
        ST_DRAIN,
        ST_RESP
    } wr_state_e;

    // log2 of the number of bytes in one data beat of width dw bits
    function automatic int beat_size_log2(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/spi_axi_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between interconnect and flash controller.
// master: drives AW/W and bready; slave: drives awready, wready and the B channel.
interface spi_axi_wr_ctrl_if #(
    parameter int DW  = 128,
    parameter int AW  = 32,
    parameter int IDW = 6
);

    logic [IDW-1:0]  awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [2:0]      awcache;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/spi_axi_page_split.sv
// Segment length for a flash access: min(rem, beats left to the page end).
// In: cur_addr (beat aligned), rem (beats left). Out: beats, 1..BPP.
module spi_axi_page_split
    import spi_axi_pkg::*;
#(
    parameter int  AW         = 32,
    parameter int  DW         = 128,
    parameter int  PAGE_BYTES = 256,
    localparam int BB         = DW / 8,
    localparam int BPP        = PAGE_BYTES / BB,
    localparam int SW         = $clog2(BPP) + 1
) (
    input  logic [AW-1:0] cur_addr,
    input  logic [8:0]    rem,
    output logic [SW-1:0] beats
);

    localparam int LBB = beat_size_log2(DW);
    localparam int PB  = $clog2(PAGE_BYTES);
    localparam int CW  = (SW > 9) ? SW : 9;

    logic [SW-2:0] off_beats;
    logic [SW-1:0] to_end;
    logic [CW-1:0] to_end_w;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] pick;
    logic          unused_addr;

    assign off_beats   = cur_addr[PB-1:LBB];
    assign unused_addr = ^{cur_addr[AW-1:PB], cur_addr[LBB-1:0]};

    always_comb begin
        to_end   = SW'(BPP) - {1'b0, off_beats};
        to_end_w = CW'(to_end);
        rem_w    = CW'(rem);
        pick     = (rem_w < to_end_w) ? rem_w : to_end_w;
        // pick never exceeds to_end, so it always fits in SW bits
        beats    = SW'(pick);
    end

endmodule

// File: rtl/spi_axi_wr_ctrl.sv
// AXI4 write slave feeding the QSPI program engine, one burst at a time,
// split into page-bounded program commands, with a single B response.
// Ports: aclk/aresetn; spi_if (AXI AW/W/B slave); prog_req/addr/beats/ack
// command; prog_wdata/wvalid/wready data; prog_done/prog_err completion.
module spi_axi_wr_ctrl
    import spi_axi_pkg::*;
#(
    parameter int  DW         = 128,
    parameter int  AW         = 32,
    parameter int  IDW        = 6,
    parameter int  PAGE_BYTES = 256,
    localparam int BB         = DW / 8,
    localparam int BPP        = PAGE_BYTES / BB,
    localparam int SW         = $clog2(BPP) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    spi_axi_wr_ctrl_if.slave  spi_if,
    output logic              prog_req,
    output logic [AW-1:0]     prog_addr,
    output logic [SW-1:0]     prog_beats,
    input  logic              prog_ack,
    output logic [DW-1:0]     prog_wdata,
    output logic              prog_wvalid,
    input  logic              prog_wready,
    input  logic              prog_done,
    input  logic              prog_err
);

    localparam int LBB = beat_size_log2(DW);

    wr_state_e      state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [8:0]     rem_q, rem_d;
    logic [SW-1:0]  seg_q, seg_d;
    logic           err_q, err_d;
    logic           rdy_q, rdy_d;

    logic [SW-1:0]  split_beats;
    logic           cfg_err;
    logic           beat_err;
    logic           w_hs;
    logic           unused_aw;

    assign unused_aw = spi_if.awlock ^ (^spi_if.awcache);

    spi_axi_page_split #(
        .AW         (AW),
        .DW         (DW),
        .PAGE_BYTES (PAGE_BYTES)
    ) u_split (
        .cur_addr (addr_q),
        .rem      (rem_q),
        .beats    (split_beats)
    );

    assign cfg_err = (spi_if.awburst != BURST_INCR)
                   | (spi_if.awsize != 3'(LBB))
                   | (spi_if.awaddr[LBB-1:0] != '0);

    assign beat_err = ~(&spi_if.wstrb)
                    | (spi_if.wlast != (rem_q == 9'd1));

    assign w_hs = spi_if.wvalid & prog_wready;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        seg_d   = seg_q;
        err_d   = err_q;
        // awready stays low for the first cycle out of reset
        rdy_d   = 1'b1;

        spi_if.awready = 1'b0;
        spi_if.wready  = 1'b0;
        spi_if.bid     = '0;
        spi_if.bresp   = RESP_OKAY;
        spi_if.bvalid  = 1'b0;
        prog_req       = 1'b0;
        prog_addr      = '0;
        prog_beats     = '0;
        prog_wdata     = '0;
        prog_wvalid    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                spi_if.awready = rdy_q;
                if (rdy_q && spi_if.awvalid) begin
                    id_d    = spi_if.awid;
                    addr_d  = spi_if.awaddr;
                    rem_d   = {1'b0, spi_if.awlen} + 9'd1;
                    err_d   = cfg_err;
                    state_d = cfg_err ? ST_DRAIN : ST_CMD;
                end
            end
            ST_CMD: begin
                prog_req   = 1'b1;
                prog_addr  = addr_q;
                prog_beats = split_beats;
                if (prog_ack) begin
                    seg_d   = split_beats;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                prog_wvalid   = spi_if.wvalid;
                prog_wdata    = spi_if.wdata;
                spi_if.wready = prog_wready;
                if (w_hs) begin
                    seg_d  = seg_q - SW'(1);
                    rem_d  = rem_q - 9'd1;
                    addr_d = addr_q + AW'(BB);
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    if (seg_q == SW'(1)) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (prog_done) begin
                    if (prog_err) begin
                        err_d = 1'b1;
                    end
                    if (prog_err && rem_q != 9'd0) begin
                        state_d = ST_DRAIN;
                    end else if (rem_q != 9'd0) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_DRAIN: begin
                if (rem_q == 9'd0) begin
                    state_d = ST_RESP;
                end else begin
                    spi_if.wready = 1'b1;
                    if (spi_if.wvalid) begin
                        rem_d = rem_q - 9'd1;
                        if (rem_q == 9'd1) begin
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_RESP: begin
                spi_if.bvalid = 1'b1;
                spi_if.bid    = id_q;
                spi_if.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (spi_if.bready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            seg_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            seg_q   <= seg_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: doc/spi_axi_wr_ctrl.md
Name: spi_axi_wr_ctrl

Overview:
- AXI4 write-slave controller in front of the QSPI flash program engine.
- Accepts one AW/W burst at a time and splits it at flash page boundaries into program commands.
- Streams W beats to the engine, waits for each page program to complete, then returns one B response.
- Sits between the system AXI interconnect and the QSPI command/datapath engine.

Parameters:
DW, 128, AXI data width in bits; beat bytes BB = DW/8.
AW, 32, AXI address width.
IDW, 6, AXI ID width.
PAGE_BYTES, 256, flash page size; must be a power of two and a multiple of BB. BPP = PAGE_BYTES/BB beats per page (16 at defaults).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
spi_if_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awvalid  in  IDW/AW/8/3/2/1/3/1  AXI write address channel
spi_if_awready  out  1  AW ready
spi_if_wdata/wstrb/wlast/wvalid  in  DW/DW/8/1/1  AXI write data channel
spi_if_wready  out  1  W ready
spi_if_bid/bresp/bvalid  out  IDW/2/1  AXI write response channel
spi_if_bready  in  1  B ready
prog_req  out  1  program command valid
prog_addr  out  AW  segment start byte address
prog_beats  out  $clog2(BPP)+1  segment length in beats, 1..BPP
prog_ack  in  1  command accepted
prog_wdata  out  DW  data beat to engine
prog_wvalid  out  1  data valid
prog_wready  in  1  engine data ready
prog_done  in  1  one-cycle pulse: segment program finished
prog_err  in  1  qualifies prog_done; segment failed

Behaviour:
- Reset: all outputs 0; FSM in IDLE; error flag cleared. Reset mid-burst abandons the transaction with no B response.
- Clock and reset: the clock is aclk; reset is aresetn, asynchronous and active-low.
- States: IDLE, CMD, DATA, WAIT, DRAIN, RESP.
- IDLE:
  - awready=1, wready=0.
  - On the AW handshake, latch id, addr and rem = awlen+1 (9 bits).
  - err = (awburst!=INCR) | (awsize!=log2(BB)) | (awaddr[log2(BB)-1:0]!=0).
  - Next state: DRAIN if err, else CMD.
  - awlock and awcache are ignored.
- CMD:
  - prog_req=1, prog_addr=cur_addr, prog_beats=min(rem, BPP - cur_addr page-offset in beats).
  - Outputs are held stable until prog_ack; then latch seg=prog_beats and go to DATA.
  - prog_req and prog_ack may both be high in the first CMD cycle.
- DATA:
  - prog_wvalid=spi_if_wvalid, spi_if_wready=prog_wready, prog_wdata=spi_if_wdata. This path is combinational, zero latency.
  - Each handshake decrements seg and rem and advances cur_addr by BB.
  - wstrb!=all-ones sets err, but the beat is still forwarded.
  - wlast!=(rem==1) sets err.
  - On the beat where seg==1, go to WAIT.
- WAIT:
  - Wait for prog_done. prog_err sets err.
  - If prog_err and rem>0, go to DRAIN.
  - Else if rem>0, go to CMD (next page).
  - Else go to RESP.
- DRAIN:
  - wready=1; beats are discarded and rem is decremented per handshake.
  - When rem reaches 0, go to RESP.
  - If rem==0 on entry, go directly to RESP.
- RESP:
  - bvalid=1, bid=latched id, bresp = err ? SLVERR(2'b10) : OKAY(2'b00).
  - On bready, go to IDLE and clear err.
  - The next AW is accepted no earlier than the cycle after the B handshake.
- Page split: a segment never crosses a PAGE_BYTES boundary. Address increments wrap modulo 2^AW.
- No outstanding transactions; AW is not accepted while busy.

Decomposition:
- Package spi_axi_pkg holds:
  - RESP_OKAY and RESP_SLVERR
  - BURST_INCR
  - the state enum
  - the helper function for log2(BB)
- One sub-module, spi_axi_page_split: combinational min(rem, beats-to-page-end) from cur_addr and rem. It is reused by the future read controller.

Test Plan:
- AW addr=0x100, len=15, size=4, INCR; 16 full-strobe beats -> one prog_req, addr=0x100, beats=16; after prog_done, bresp=OKAY and bid echoes awid.
- AW addr=0x1C0, len=7 -> two commands: (0x1C0, 4) then (0x200, 4); the second prog_req appears only after the first prog_done; bresp=OKAY.
- AW addr=0x104 (misaligned), len=3 -> no prog_req; 4 W beats accepted with wready=1; bresp=SLVERR.
- AW addr=0x0, len=31; first prog_done has prog_err=1 -> no second command; remaining 16 beats drained; bresp=SLVERR.
- Random prog_wready/wvalid/bready stalls on a 64-beat burst -> every beat forwarded exactly once and in order; prog_* outputs stable while prog_req is held without prog_ack.
- aresetn asserted during DATA -> all outputs 0 immediately; after release, a new burst completes with OKAY.
